// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential neuron: FSM state encoding,
// accumulator sizing and the signed clamp used at the output.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest accumulator the clamp helper handles.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    sat;
    } sat_res_t;

    function automatic int acc_width(input int w, input int n_in);
        return w + $clog2(n_in + 1);
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic sat_res_t sat_to_w(input logic signed [SAT_W-1:0] a, input int w);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_res_t                r;
        max_v   = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v   = -max_v - 64'sd1;
        r.value = a;
        r.sat   = 1'b0;
        if (a > max_v) begin
            r.value = max_v;
            r.sat   = 1'b1;
        end else if (a < min_v) begin
            r.value = min_v;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_lane_sum.sv
// Combinational masked adder: sums the weights of the active, in-range lanes
// of one accumulate step, sign-extended to the accumulator width.
module neuron_lane_sum #(
    parameter int LANES = 1,
    parameter int W     = 20,
    parameter int ACC_W = 24
) (
    input  logic [LANES-1:0]        x_slice,
    input  logic [LANES*W-1:0]      w_slice,
    input  logic [LANES-1:0]        lane_mask,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0] term [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign term[gi] = (x_slice[gi] && lane_mask[gi])
                ? {{(ACC_W-W){w_slice[gi*W+W-1]}}, w_slice[gi*W +: W]}
                : '0;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int j = 0; j < LANES; j++) begin
            sum = sum + term[j];
        end
    end

endmodule

// File: rtl/seq_neuron.sv
// Multi-cycle binary-pixel neuron: accumulates LANES weighted pixels per cycle,
// then presents a saturated result. Define SEQ_NEURON_RELU_EN to zero negative results.
module seq_neuron
    import neuron_pkg::*;
#(
    parameter int N_IN  = 9,
    parameter int W     = 20,
    parameter int LANES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN-1:0]     x,
    input  logic [N_IN*W-1:0]   w,
    input  logic [W-1:0]        b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] d_out,
    output logic                sat
);

    localparam int ACC_W    = acc_width(W, N_IN);
    localparam int STEPS    = (N_IN + LANES - 1) / LANES;
    localparam int PAD      = STEPS * LANES;
    localparam int IDX_W    = $clog2(PAD + 1);
    localparam int LAST_IDX = (STEPS - 1) * LANES;

    state_t                  state_reg, state_next;
    logic [PAD-1:0]          x_reg;
    logic [PAD*W-1:0]        w_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [W-1:0]     d_out_reg, d_out_next;
    logic                    sat_reg, sat_next;

    logic [LANES-1:0]        x_slice;
    logic [LANES*W-1:0]      w_slice;
    logic [LANES-1:0]        lane_mask;
    logic signed [ACC_W-1:0] part_sum;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [SAT_W-1:0] acc_ext;
    sat_res_t                sat_res;
    logic                    last_step;
    logic                    accept;

    // Operands are zero-padded to a whole number of steps so the final
    // slice never runs off the end; the mask still blanks padded lanes.
    assign x_slice = x_reg[int'(idx_reg) +: LANES];
    assign w_slice = w_reg[int'(idx_reg)*W +: LANES*W];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
            assign lane_mask[gi] = (int'(idx_reg) + gi) < N_IN;
        end
    endgenerate

    neuron_lane_sum #(
        .LANES (LANES),
        .W     (W),
        .ACC_W (ACC_W)
    ) u_lane_sum (
        .x_slice   (x_slice),
        .w_slice   (w_slice),
        .lane_mask (lane_mask),
        .sum       (part_sum)
    );

    assign acc_sum   = acc_reg + part_sum;
    assign acc_ext   = {{(SAT_W-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
    assign sat_res   = sat_to_w(acc_ext, W);
    assign last_step = (idx_reg == IDX_W'(LAST_IDX));

    always_comb begin
        sat_next   = sat_res.sat;
        d_out_next = sat_res.value[W-1:0];
`ifdef SEQ_NEURON_RELU_EN
        if (sat_res.value[SAT_W-1]) begin
            d_out_next = '0;
        end
`endif
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign d_out     = d_out_reg;
    assign sat       = sat_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = ACC;
            ACC:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            w_reg     <= '0;
            idx_reg   <= '0;
            acc_reg   <= '0;
            d_out_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && accept) begin
                x_reg   <= PAD'(x);
                w_reg   <= (PAD*W)'(w);
                acc_reg <= {{(ACC_W-W){b[W-1]}}, b};
                idx_reg <= '0;
            end
            if (state_reg == ACC) begin
                acc_reg <= acc_sum;
                idx_reg <= idx_reg + IDX_W'(LANES);
                if (last_step) begin
                    d_out_reg <= d_out_next;
                    sat_reg   <= sat_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_neuron.sv
// Directed bench for seq_neuron: a LANES=1 instance and a LANES=4 instance
// share the operand buses; each has its own handshake signals.
module tb_seq_neuron;

    localparam int N  = 9;
    localparam int WW = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      x;
    logic [N*WW-1:0]   w;
    logic [WW-1:0]     b;

    logic              in_valid1, in_ready1, out_valid1, out_ready1, sat1;
    logic signed [WW-1:0] d_out1;
    logic              in_valid4, in_ready4, out_valid4, out_ready4, sat4;
    logic signed [WW-1:0] d_out4;

    int checks   = 0;
    int failures = 0;

    logic [N*WW-1:0] w_inc;
    logic [N*WW-1:0] w_max;
    logic [N*WW-1:0] w_min;
    logic [N*WW-1:0] w_sparse;
    longint          exp_neg7;
    longint          exp_min;
    longint          exp_neg1;

    always #5 clk = ~clk;

    seq_neuron #(.N_IN(N), .W(WW), .LANES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .x         (x),
        .w         (w),
        .b         (b),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .d_out     (d_out1),
        .sat       (sat1)
    );

    seq_neuron #(.N_IN(N), .W(WW), .LANES(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .x         (x),
        .w         (w),
        .b         (b),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .d_out     (d_out4),
        .sat       (sat4)
    );

    task automatic check(input string tag, input longint obs, input longint exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One full transaction on the selected instance. Latency counts clock
    // edges from the accept edge (inclusive) to the edge that raises out_valid.
    task automatic run_txn(input int sel, input string tag, input logic [N-1:0] xv,
                           input logic [N*WW-1:0] wv, input logic [WW-1:0] bv,
                           input int exp_lat, input longint exp_d, input logic exp_sat);
        int edges;
        x = xv;
        w = wv;
        b = bv;
        if (sel == 0) in_valid1 = 1'b1; else in_valid4 = 1'b1;
        check({tag, ".in_ready"}, (sel == 0) ? in_ready1 : in_ready4, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        edges = 1;
        while (((sel == 0) ? out_valid1 : out_valid4) !== 1'b1 && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ".latency"}, edges, exp_lat);
        check({tag, ".d_out"}, (sel == 0) ? d_out1 : d_out4, exp_d);
        check({tag, ".sat"}, (sel == 0) ? sat1 : sat4, exp_sat);
        if (sel == 0) out_ready1 = 1'b1; else out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        out_ready4 = 1'b0;
        check({tag, ".out_valid_drop"}, (sel == 0) ? out_valid1 : out_valid4, 0);
        $display("txn %s: d_out=%0d sat=%0d latency=%0d", tag,
                 (sel == 0) ? d_out1 : d_out4, (sel == 0) ? sat1 : sat4, edges);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            w_inc[i*WW +: WW]    = WW'(i + 1);
            w_max[i*WW +: WW]    = 20'h7FFFF;
            w_min[i*WW +: WW]    = 20'h80000;
            w_sparse[i*WW +: WW] = 20'd100;
        end
        w_sparse[0*WW +: WW] = 20'd3;
        w_sparse[2*WW +: WW] = 20'd4;
`ifdef SEQ_NEURON_RELU_EN
        exp_neg7 = 0;
        exp_min  = 0;
        exp_neg1 = 0;
`else
        exp_neg7 = -7;
        exp_min  = -524288;
        exp_neg1 = -1;
`endif

        rst = 1'b1;
        x = '0; w = '0; b = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", in_ready1, 0);
        check("reset.out_valid", out_valid1, 0);
        check("reset.d_out", d_out1, 0);
        check("reset.sat", sat1, 0);
        rst = 1'b0;
        #1;
        check("release.in_ready", in_ready1, 1);
        check("release.in_ready4", in_ready4, 1);

        // 1+..+9 = 45, minus 5
        run_txn(0, "inc_bias", 9'h1FF, w_inc, -20'sd5, 10, 40, 1'b0);
        run_txn(0, "zero_x", 9'h000, w_inc, -20'sd7, 10, exp_neg7, 1'b0);
        run_txn(0, "sat_pos", 9'h1FF, w_max, 20'd0, 10, 524287, 1'b1);
        run_txn(0, "sat_neg", 9'h1FF, w_min, 20'd0, 10, exp_min, 1'b1);

        // Hold DONE with out_ready low while new data is offered.
        x = 9'h1FF; w = w_inc; b = 20'd0;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        for (int k = 0; k < 20 && out_valid1 !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        check("hold.first", d_out1, 45);
        for (int k = 0; k < 5; k++) begin
            x = 9'h000; b = 20'd100;
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            check("hold.d_out", d_out1, 45);
            check("hold.out_valid", out_valid1, 1);
            check("hold.in_ready", in_ready1, 0);
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("hold.release_valid", out_valid1, 0);
        check("hold.release_ready", in_ready1, 1);
        $display("txn hold: d_out=45 held 5 cycles");
        run_txn(0, "after_hold", 9'h003, w_inc, 20'd0, 10, 3, 1'b0);

        // Reset three cycles into accumulation.
        x = 9'h1FF; w = w_inc; b = 20'd0;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst.out_valid", out_valid1, 0);
        check("midrst.d_out", d_out1, 0);
        check("midrst.in_ready", in_ready1, 0);
        rst = 1'b0;
        #1;
        check("midrst.release", in_ready1, 1);
        $display("txn midrst: aborted");
        run_txn(0, "sparse", 9'h005, w_sparse, 20'd1, 10, 8, 1'b0);

        // Four lanes: STEPS=3, last step has one live lane.
        run_txn(1, "lanes4_inc", 9'h1FF, w_inc, 20'd0, 4, 45, 1'b0);
        run_txn(1, "lanes4_last", 9'h100, w_inc, -20'sd10, 4, exp_neg1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
